// File: rtl/mure_pkg.sv
// Shared types for the multiple-retirement trace path: retired uop entry,
// buffered commit group and sequencer state encoding.
package mure_pkg;

  localparam int NRET    = 2;
  localparam int XLEN    = 32;
  localparam int CAUSE_W = 5;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [31:0]        inst_data;
    logic               compressed;
    logic               exception;
    logic               interrupt;
    logic               eret;
    logic [CAUSE_W-1:0] cause;
    logic [XLEN-1:0]    tval;
    logic [1:0]         priv;
  } uop_entry_s;

  typedef struct packed {
    logic [NRET-1:0]            mask;
    uop_entry_s [NRET-1:0]      uop;
  } mure_group_s;

  typedef enum logic {
    SEQ_EMPTY = 1'b0,
    SEQ_ISSUE = 1'b1
  } seq_state_e;

endpackage

// File: rtl/mure_group_fifo.sv
// DEPTH-entry synchronous FIFO of commit groups. Head is a registered-pointer
// read (no fall-through); the mask of the entry behind the head is exposed too.
module mure_group_fifo
  import mure_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  mure_group_s       wdata_i,
  output mure_group_s       head_o,
  output logic [NRET-1:0]   next_mask_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  mure_group_s            mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       rd_ptr_nxt;
  logic [CNT_W-1:0]       count;
  logic                   do_push;
  logic                   do_pop;

  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign rd_ptr_nxt = rd_ptr + 1'b1;

  assign full_o      = (count == CNT_W'(DEPTH));
  assign empty_o     = (count == '0);
  assign count_o     = count;
  assign head_o      = mem[rd_ptr];
  assign next_mask_o = mem[rd_ptr_nxt].mask;

  // Group storage carries no reset; only pointers and count are control.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr_nxt;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mure_retire_sequencer.sv
// Serialises buffered multi-port commit groups into one ordered uop stream,
// lowest port first. Optional drop counter enabled by MURE_DROP_CNT_EN.
module mure_retire_sequencer
  import mure_pkg::*;
#(
  parameter  int NRET   = mure_pkg::NRET,
  parameter  int DEPTH  = 4,
  localparam int PORT_W = (NRET > 1) ? $clog2(NRET) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NRET-1:0]         valid_i,
  input  uop_entry_s [NRET-1:0]   uop_i,
  output logic                    ready_o,
  output logic                    valid_o,
  output uop_entry_s              uop_o,
  output logic [PORT_W-1:0]       port_o,
  output logic                    last_o,
  input  logic                    ready_i
`ifdef MURE_DROP_CNT_EN
  ,
  output logic [15:0]             drop_cnt_o
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  function automatic logic [PORT_W-1:0] lowest_port(input logic [NRET-1:0] m);
    lowest_port = '0;
    for (int i = NRET - 1; i >= 0; i--) begin
      if (m[i]) lowest_port = PORT_W'(i);
    end
  endfunction

  function automatic logic single_bit(input logic [NRET-1:0] m);
    return (m != '0) && ((m & (m - 1'b1)) == '0);
  endfunction

  seq_state_e          state_q;
  seq_state_e          state_d;
  logic [NRET-1:0]     rem_mask;
  mure_group_s         wr_group;
  mure_group_s         head;
  logic [NRET-1:0]     next_mask;
  logic                full;
  logic                empty;
  logic [CNT_W-1:0]    count;
  logic                push;
  logic                xfer;
  logic                pop;
  logic [PORT_W-1:0]   sel_port;

  assign ready_o        = !full;
  assign push           = (|valid_i) && ready_o;
  assign xfer           = valid_o && ready_i;
  assign pop            = xfer && last_o;
  assign sel_port       = lowest_port(rem_mask);
  assign wr_group.mask  = valid_i;
  assign wr_group.uop   = uop_i;

  mure_group_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .pop_i       (pop),
    .wdata_i     (wr_group),
    .head_o      (head),
    .next_mask_o (next_mask),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (count)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= SEQ_EMPTY;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    valid_o = 1'b0;
    uop_o   = '0;
    port_o  = '0;
    last_o  = 1'b0;
    case (state_q)
      SEQ_EMPTY: begin
        if (push) state_d = SEQ_ISSUE;
      end
      SEQ_ISSUE: begin
        valid_o = 1'b1;
        port_o  = sel_port;
        uop_o   = head.uop[sel_port];
        last_o  = single_bit(rem_mask);
        // Only the final pop with no refill and no incoming group empties us.
        if (pop && (count == CNT_W'(1)) && !push) state_d = SEQ_EMPTY;
      end
      default: state_d = SEQ_EMPTY;
    endcase
  end

  // rem_mask tracks the head group's not-yet-emitted ports.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rem_mask <= '0;
    end else if (state_q == SEQ_EMPTY) begin
      if (push) rem_mask <= valid_i;
    end else if (xfer) begin
      if (!last_o)                  rem_mask <= rem_mask & ~(NRET'(1) << sel_port);
      else if (count > CNT_W'(1))   rem_mask <= next_mask;
      else if (push)                rem_mask <= valid_i;
      else                          rem_mask <= '0;
    end
  end

`ifdef MURE_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      drop_cnt_q <= '0;
    end else if ((|valid_i) && !ready_o && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  // Without the counter, a group arriving at a full FIFO is dropped silently.
`endif

  logic unused_empty;
  assign unused_empty = empty;

endmodule
